hbitcounter_pipe: RTL and testbench

//  Pipelined, streaming successor to the combinational high-bit counter. Counts set bits of each

---
 rtl/hbitcounter_pipe_if.sv | 39 +++
 rtl/hbitcounter_pipe.sv | 108 ++++++++++
 tb/tb_hbitcounter_pipe.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/hbitcounter_pipe_if.sv
// Streaming handshake bundle for hbitcounter_pipe.
// The accumulator signals exist only when HBITCNT_ACCUM_EN is defined.
interface hbitcounter_pipe_if #(
    parameter int DATA_WIDTH = 16,
    parameter int ACC_WIDTH  = 16
);
    localparam int CNT_W = $clog2(DATA_WIDTH) + 1;

    logic                  s_valid;
    logic                  s_ready;
    logic [DATA_WIDTH-1:0] s_data;
    logic                  s_last;
    logic                  m_valid;
    logic                  m_ready;
    logic [CNT_W-1:0]      m_count;
    logic                  m_last;
`ifdef HBITCNT_ACCUM_EN
    logic [ACC_WIDTH-1:0]  m_acc;
    logic                  m_acc_ovf;
`endif

    // Design-side view: consumes the input stream, produces the result stream.
    modport slave (
        input  s_valid, s_data, s_last, m_ready,
        output s_ready, m_valid, m_count, m_last
`ifdef HBITCNT_ACCUM_EN
        , output m_acc, m_acc_ovf
`endif
    );

    // Environment-side view: produces words, consumes results.
    modport master (
        output s_valid, s_data, s_last, m_ready,
        input  s_ready, m_valid, m_count, m_last
`ifdef HBITCNT_ACCUM_EN
        , input m_acc, m_acc_ovf
`endif
    );
endinterface

// File: rtl/hbitcounter_pipe.sv
// Two-stage pipelined popcount with valid/ready flow control on both sides.
// Stage 1 holds per-chunk partial counts, stage 2 holds the summed count.
// Optional per-frame running total enabled by defining HBITCNT_ACCUM_EN.
module hbitcounter_pipe #(
    parameter int DATA_WIDTH = 16,
    parameter int CHUNK_W    = 4,
    parameter int ACC_WIDTH  = 16
) (
    input  logic             clk,
    input  logic             rst,
    hbitcounter_pipe_if.slave bus
);
    localparam int CNT_W  = $clog2(DATA_WIDTH) + 1;
    localparam int NCHUNK = DATA_WIDTH / CHUNK_W;
    localparam int PW     = $clog2(CHUNK_W) + 1;

    logic [NCHUNK-1:0][PW-1:0] part_q, part_d;
    logic                      last1_q;
    logic                      v1_q;
    logic [CNT_W-1:0]          count_q, count_d;
    logic                      last_q;
    logic                      mvalid_q;
    logic                      adv;
    logic                      s_ready;

    // Output stage advances when empty or being drained; stage 1 may also
    // refill while the output is stalled as long as it is itself empty.
    assign adv     = !mvalid_q || bus.m_ready;
    assign s_ready = adv || !v1_q;

    assign bus.s_ready = s_ready;
    assign bus.m_valid = mvalid_q;
    assign bus.m_count = count_q;
    assign bus.m_last  = last_q;

    // Per-chunk partial popcounts of the incoming word.
    always_comb begin
        part_d = '0;
        for (int i = 0; i < NCHUNK; i++) begin
            for (int j = 0; j < CHUNK_W; j++) begin
                part_d[i] = part_d[i] + PW'(bus.s_data[i*CHUNK_W+j]);
            end
        end
    end

    // Sum of the registered partials, zero-extended to the result width.
    always_comb begin
        count_d = '0;
        for (int i = 0; i < NCHUNK; i++) begin
            count_d = count_d + CNT_W'(part_q[i]);
        end
    end

    // Stage 1 and output stage registers; data fields only load with a real word.
    always_ff @(posedge clk) begin
        if (rst) begin
            part_q   <= '0;
            last1_q  <= 1'b0;
            v1_q     <= 1'b0;
            count_q  <= '0;
            last_q   <= 1'b0;
            mvalid_q <= 1'b0;
        end else begin
            if (s_ready) begin
                v1_q <= bus.s_valid;
                if (bus.s_valid) begin
                    part_q  <= part_d;
                    last1_q <= bus.s_last;
                end
            end
            if (adv) begin
                mvalid_q <= v1_q;
                if (v1_q) begin
                    count_q <= count_d;
                    last_q  <= last1_q;
                end
            end
        end
    end

`ifdef HBITCNT_ACCUM_EN
    logic [ACC_WIDTH-1:0] acc_q, acc_d, acc_base;
    logic                 ovf_q, ovf_d;
    logic [ACC_WIDTH:0]   acc_sum;

    assign bus.m_acc     = acc_q;
    assign bus.m_acc_ovf = ovf_q;

    // A word following a frame end (or reset, where acc is already zero) starts from zero.
    always_comb begin
        acc_base = last_q ? '0 : acc_q;
        acc_sum  = {1'b0, acc_base} + (ACC_WIDTH+1)'(count_d);
        acc_d    = acc_sum[ACC_WIDTH] ? '1 : acc_sum[ACC_WIDTH-1:0];
        ovf_d    = (last_q ? 1'b0 : ovf_q) | acc_sum[ACC_WIDTH];
    end

    // Running total advances in lockstep with the word moving into the output stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= '0;
            ovf_q <= 1'b0;
        end else if (adv && v1_q) begin
            acc_q <= acc_d;
            ovf_q <= ovf_d;
        end
    end
`endif
endmodule

// File: tb/tb_hbitcounter_pipe.sv
// Scoreboard bench for hbitcounter_pipe (DATA_WIDTH=16, CHUNK_W=4, ACC_WIDTH=8).
// Frame accumulator checks are compiled in when HBITCNT_ACCUM_EN is defined.
module tb_hbitcounter_pipe;
    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    typedef struct {
        logic [4:0] cnt;
        logic       last;
        logic [7:0] acc;
        logic       ovf;
    } exp_t;
    exp_t q[$];

    hbitcounter_pipe_if #(.DATA_WIDTH(16), .ACC_WIDTH(8)) bus ();

    hbitcounter_pipe #(.DATA_WIDTH(16), .CHUNK_W(4), .ACC_WIDTH(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Offer one word; record expectation once it is accepted.
    task automatic send(input logic [15:0] d, input logic l, input logic [4:0] c,
                        input logic [7:0] a, input logic o, output int waits);
        exp_t e;
        bit   done = 0;
        waits = 0;
        @(negedge clk);
        bus.s_valid = 1'b1;
        bus.s_data  = d;
        bus.s_last  = l;
        for (int k = 0; k < 50; k++) begin
            if (bus.s_ready) begin
                @(posedge clk);
                done = 1;
                break;
            end
            waits++;
            @(negedge clk);
        end
        if (!done) begin
            bad++;
            total++;
            $display("FAIL send_timeout actual=%0h required=accepted", d);
        end else begin
            e.cnt = c; e.last = l; e.acc = a; e.ovf = o;
            q.push_back(e);
        end
        #1;
        bus.s_valid = 1'b0;
        bus.s_data  = 16'($urandom);
        bus.s_last  = 1'($urandom);
    endtask

    // Monitor: every delivered result is checked against the queue head.
    always @(negedge clk) begin
        if (!rst && bus.m_valid && bus.m_ready) begin
            if (q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_output actual=%0h required=none", bus.m_count);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("m_count", 32'(bus.m_count), 32'(e.cnt));
                chk("m_last", 32'(bus.m_last), 32'(e.last));
`ifdef HBITCNT_ACCUM_EN
                chk("m_acc", 32'(bus.m_acc), 32'(e.acc));
                chk("m_acc_ovf", 32'(bus.m_acc_ovf), 32'(e.ovf));
`endif
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        rst = 1'b1;
        bus.s_valid = 1'b0;
        bus.s_data  = '0;
        bus.s_last  = 1'b0;
        bus.m_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_m_valid", 32'(bus.m_valid), 0);
        chk("rst_m_count", 32'(bus.m_count), 0);
        chk("rst_m_last", 32'(bus.m_last), 0);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_s_ready", 32'(bus.s_ready), 1);

        // 1: single word latency and one-cycle valid
        send(16'hF0F1, 1'b1, 5'd9, 8'd9, 1'b0, w);
        @(negedge clk);
        chk("lat_n0_valid", 32'(bus.m_valid), 0);
        @(negedge clk);
        chk("lat_n1_valid", 32'(bus.m_valid), 1);
        @(negedge clk);
        chk("lat_n2_valid", 32'(bus.m_valid), 0);

        // 2: back-to-back, no stalls expected
        send(16'h0000, 1'b1, 5'd0,  8'd0,  1'b0, w); chk("b2b_wait0", 32'(w), 0);
        send(16'hFFFF, 1'b1, 5'd16, 8'd16, 1'b0, w); chk("b2b_wait1", 32'(w), 0);
        send(16'h8001, 1'b1, 5'd2,  8'd2,  1'b0, w); chk("b2b_wait2", 32'(w), 0);
        repeat (4) @(negedge clk);

        // 3: downstream stall with four words
        @(posedge clk); #1 bus.m_ready = 1'b0;
        send(16'h1234, 1'b1, 5'd5,  8'd5,  1'b0, w);
        send(16'hFFFE, 1'b1, 5'd15, 8'd15, 1'b0, w);
        @(negedge clk);
        chk("stall_s_ready", 32'(bus.s_ready), 0);
        chk("stall_m_valid", 32'(bus.m_valid), 1);
        chk("stall_hold0", 32'(bus.m_count), 5);
        fork
            begin
                send(16'h0101, 1'b1, 5'd2, 8'd2, 1'b0, w);
                send(16'h7000, 1'b1, 5'd3, 8'd3, 1'b0, w);
            end
            begin
                repeat (3) begin
                    @(negedge clk);
                    chk("stall_hold", 32'(bus.m_count), 5);
                    chk("stall_ready_low", 32'(bus.s_ready), 0);
                end
                @(posedge clk); #1 bus.m_ready = 1'b1;
            end
        join
        repeat (6) @(negedge clk);
        chk("stall_drained", 32'(q.size()), 0);

        // 4: reset with two words in flight
        @(posedge clk); #1 bus.m_ready = 1'b0;
        send(16'h00F0, 1'b1, 5'd4, 8'd4, 1'b0, w);
        send(16'h0F00, 1'b1, 5'd4, 8'd4, 1'b0, w);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1 q.delete();
        @(negedge clk);
        chk("midrst_m_valid", 32'(bus.m_valid), 0);
        chk("midrst_m_count", 32'(bus.m_count), 0);
        chk("midrst_s_ready", 32'(bus.s_ready), 1);
        rst = 1'b0;
        bus.m_ready = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("midrst_no_stale", 32'(bus.m_valid), 0);
        end

`ifdef HBITCNT_ACCUM_EN
        // 5: frame totals
        send(16'h00FF, 1'b0, 5'd8, 8'd8,  1'b0, w);
        send(16'h0F0F, 1'b0, 5'd8, 8'd16, 1'b0, w);
        send(16'h0001, 1'b1, 5'd1, 8'd17, 1'b0, w);
        send(16'h0003, 1'b1, 5'd2, 8'd2,  1'b0, w);

        // 6: saturation at 16th word of 16'hFFFF, cleared next frame
        for (int k = 1; k <= 17; k++) begin
            send(16'hFFFF, (k == 17), 5'd16, (k >= 16) ? 8'd255 : 8'(16 * k), (k >= 16), w);
        end
        send(16'h0001, 1'b1, 5'd1, 8'd1, 1'b0, w);
`endif

        for (int k = 0; k < 100 && q.size() != 0; k++) @(negedge clk);
        chk("final_drain", 32'(q.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
